// File: rtl/s27_seq_pkg.sv
// ---------------------------------------------------------------------------
// s27_seq_pkg
// Shared types, constants and next-state helpers for the s27 self-test
// sequencer: FSM state enum, MISR polynomial, init vector, LFSR taps and
// widths.
// Optional feature macro used by the block: S27_SEQ_ABORT_EN.
// ---------------------------------------------------------------------------
package s27_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        RUN   = 2'd2,
        CHECK = 2'd3
    } seq_state_e;

    localparam int          SIG_W       = 8;
    localparam int          LFSR_W      = 4;
    localparam int          CNT_W       = 8;
    localparam int          LFSR_TAP_HI = 3;
    localparam int          LFSR_TAP_LO = 2;
    localparam logic [7:0]  MISR_POLY   = 8'h1D;
    localparam logic [3:0]  INIT_VEC    = 4'b1111;

    // One MISR step: shift left, fold the polynomial back in when the MSB
    // falls off, then absorb the serial input bit in the LSB.
    function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] sig,
                                                   input logic             din);
        logic [SIG_W-1:0] fb;
        fb = sig[SIG_W-1] ? MISR_POLY : 8'h00;
        return {sig[SIG_W-2:0], 1'b0} ^ fb ^ {{(SIG_W-1){1'b0}}, din};
    endfunction

    // Fibonacci LFSR step; maximal length (period 15), never reaches zero
    // from a nonzero seed.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
        return {l[LFSR_W-2:0], l[LFSR_TAP_HI] ^ l[LFSR_TAP_LO]};
    endfunction

endpackage

// File: rtl/s27_test_sequencer_if.sv
// ---------------------------------------------------------------------------
// s27_test_sequencer_if
// Bundles the sequencer's control/result signals and the s27 core hookup.
//   start       : begin sequence (sampled in IDLE)
//   golden_sig  : expected signature (sampled in CHECK)
//   dut_g17     : G17 output of the s27 core
//   dut_pi      : drives {G3,G2,G1,G0} of the s27 core
//   busy/done/pass/signature : status and result
//   abort/aborted : present only when S27_SEQ_ABORT_EN is defined
// Modport slave is the sequencer; master is the environment around it.
// ---------------------------------------------------------------------------
interface s27_test_sequencer_if;
    import s27_seq_pkg::*;

    logic             start;
    logic [SIG_W-1:0] golden_sig;
    logic             dut_g17;
    logic [3:0]       dut_pi;
    logic             busy;
    logic             done;
    logic             pass;
    logic [SIG_W-1:0] signature;
`ifdef S27_SEQ_ABORT_EN
    logic             abort;
    logic             aborted;
`endif

    modport slave (
        input  start, golden_sig, dut_g17,
`ifdef S27_SEQ_ABORT_EN
        input  abort,
        output aborted,
`endif
        output dut_pi, busy, done, pass, signature
    );

    modport master (
        output start, golden_sig, dut_g17,
`ifdef S27_SEQ_ABORT_EN
        output abort,
        input  aborted,
`endif
        input  dut_pi, busy, done, pass, signature
    );

endinterface

// File: rtl/s27_seq_misr.sv
// ---------------------------------------------------------------------------
// s27_seq_misr
// 8-bit serial-input signature register for compacting the s27 G17 output.
//   CK    : clock, rising edge
//   RN    : asynchronous active-low reset (signature -> 0)
//   i_clr : synchronous clear, has priority over i_en
//   i_en  : absorb i_din on this edge
//   i_din : serial input bit
//   o_sig : current signature (registered)
// ---------------------------------------------------------------------------
module s27_seq_misr
    import s27_seq_pkg::*;
(
    input  logic             CK,
    input  logic             RN,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_din,
    output logic [SIG_W-1:0] o_sig
);

    logic [SIG_W-1:0] r_sig;

    // Signature register: clear, compact, or hold.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_sig <= 8'h00;
        end else if (i_clr) begin
            r_sig <= 8'h00;
        end else if (i_en) begin
            r_sig <= misr_next(r_sig, i_din);
        end else begin
            r_sig <= r_sig;
        end
    end

    assign o_sig = r_sig;

endmodule

// File: rtl/s27_test_sequencer.sv
// ---------------------------------------------------------------------------
// s27_test_sequencer
// Self-test sequencer for the s27 benchmark core: holds the init vector for
// INIT_CYCLES cycles, applies NUM_PATTERNS LFSR patterns while compacting
// G17 into a MISR, then compares against golden_sig and pulses done.
//   CK   : clock, rising edge
//   RN   : asynchronous active-low reset
//   bus  : s27_test_sequencer_if.slave (start, golden_sig, dut_g17 in;
//          dut_pi, busy, done, pass, signature out)
// Optional: S27_SEQ_ABORT_EN adds abort/aborted to the interface; abort
// while busy returns to IDLE with no done pulse and pulses aborted.
// ---------------------------------------------------------------------------
module s27_test_sequencer
    import s27_seq_pkg::*;
#(
    parameter int          INIT_CYCLES  = 2,
    parameter int          NUM_PATTERNS = 64,
    parameter logic [3:0]  LFSR_SEED    = 4'h1
)(
    input  logic                 CK,
    input  logic                 RN,
    s27_test_sequencer_if.slave  bus
);

    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] PAT_LAST  = CNT_W'(NUM_PATTERNS - 1);

    seq_state_e        r_state;
    logic [LFSR_W-1:0] r_lfsr;
    logic [CNT_W-1:0]  r_cnt;
    logic [3:0]        r_dut_pi;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [SIG_W-1:0]  w_sig;
    logic              w_misr_clr;
    logic              w_misr_en;
    logic              w_abort_hit;

    // Abort qualification; abort only matters while a sequence is active.
    always_comb begin
        w_abort_hit = 1'b0;
`ifdef S27_SEQ_ABORT_EN
        if (bus.abort && (r_state != IDLE)) begin
            w_abort_hit = 1'b1;
        end else begin
            w_abort_hit = 1'b0;
        end
`endif
    end

    // MISR control: clear when a start is accepted, compact during RUN.
    always_comb begin
        w_misr_clr = (r_state == IDLE) && bus.start;
        w_misr_en  = (r_state == RUN) && !w_abort_hit;
    end

    s27_seq_misr u_misr (
        .CK    (CK),
        .RN    (RN),
        .i_clr (w_misr_clr),
        .i_en  (w_misr_en),
        .i_din (bus.dut_g17),
        .o_sig (w_sig)
    );

    // Sequencer FSM with registered core stimulus and status outputs.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_state  <= IDLE;
            r_lfsr   <= LFSR_SEED;
            r_cnt    <= 8'd0;
            r_dut_pi <= 4'b0000;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_abort_hit) begin
                r_state  <= IDLE;
                r_lfsr   <= LFSR_SEED;
                r_cnt    <= 8'd0;
                r_dut_pi <= 4'b0000;
                r_busy   <= 1'b0;
                r_pass   <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (bus.start) begin
                            r_state  <= INIT;
                            r_cnt    <= 8'd0;
                            r_dut_pi <= INIT_VEC;
                            r_busy   <= 1'b1;
                            r_pass   <= 1'b0;
                        end else begin
                            r_dut_pi <= 4'b0000;
                        end
                    end
                    INIT: begin
                        if (r_cnt == INIT_LAST) begin
                            r_state  <= RUN;
                            r_cnt    <= 8'd0;
                            r_lfsr   <= LFSR_SEED;
                            r_dut_pi <= LFSR_SEED;
                        end else begin
                            r_cnt    <= r_cnt + 8'd1;
                        end
                    end
                    RUN: begin
                        // The pattern for the next cycle is the advanced LFSR,
                        // so dut_pi always equals r_lfsr during RUN.
                        r_lfsr <= lfsr_next(r_lfsr);
                        if (r_cnt == PAT_LAST) begin
                            r_state  <= CHECK;
                            r_cnt    <= 8'd0;
                            r_dut_pi <= 4'b0000;
                        end else begin
                            r_cnt    <= r_cnt + 8'd1;
                            r_dut_pi <= lfsr_next(r_lfsr);
                        end
                    end
                    CHECK: begin
                        r_pass   <= (w_sig == bus.golden_sig);
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= IDLE;
                        r_dut_pi <= 4'b0000;
                    end
                    default: begin
                        r_state  <= IDLE;
                        r_cnt    <= 8'd0;
                        r_dut_pi <= 4'b0000;
                        r_busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef S27_SEQ_ABORT_EN
    logic r_aborted;

    // One-cycle acknowledge of an accepted abort.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_aborted <= 1'b0;
        end else begin
            r_aborted <= w_abort_hit;
        end
    end

    assign bus.aborted = r_aborted;
`endif

    assign bus.dut_pi    = r_dut_pi;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.signature = w_sig;

endmodule
